mc_lsu: RTL and testbench
=========================

Name: mc_lsu

Overview:
Parametrised load/store unit for the multi-cycle LoongArch core. It replaces the fixed one-cycle, word-only data-SRAM access with an SRAM-like handshake (req/addr_ok/data_ok) that tolerates variable memory latency. It supports byte, half, word and (when DATA_W=64) double accesses, with sign or zero extension, lane steering, write strobes and alignment-exception detection. The CPU MEM state issues one command and waits for exactly one response.

Parameters:
DATA_W, 32, data bus width; legal values are 32 or 64.
ADDR_W, 32, byte-address width.
CNT_W, 32, width of the saturating stall counter.

Ports:
clk  in  1  clock
resetn  in  1  reset
cmd_valid  in  1  command offered by the CPU
cmd_ready  out  1  LSU idle and able to accept a command
cmd_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size (0 B, 1 H, 2 W, 3 D)
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  store data, right-aligned
cmd_rd  in  5  destination register tag, returned with the response
rsp_valid  out  1  response available
rsp_ready  in  1  CPU accepts the response
rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults
rsp_rd  out  5  echoed tag
rsp_ale  out  1  alignment error; no memory access was made
mem_req  out  1  memory request
mem_wr  out  1  1 = write
mem_size  out  2  copy of cmd_op[1:0]
mem_addr  out  ADDR_W  full byte address
mem_wstrb  out  DATA_W/8  byte-lane write enables
mem_wdata  out  DATA_W  store data replicated across lanes
mem_addr_ok  in  1  request accepted
mem_rdata  in  DATA_W  read data
mem_data_ok  in  1  data returned / write completed
stall_cnt  out  CNT_W  count of cycles spent in REQ plus WAIT, saturating

Behaviour:
- Reset: synchronous, active-low, signal resetn, clock clk. The FSM returns to IDLE. cmd_ready=1; rsp_valid, mem_req, mem_wr, rsp_ale=0; rsp_rdata, rsp_rd, mem_addr, mem_wstrb, mem_wdata, mem_size=0; stall_cnt=0.
- Reset mid-transaction aborts without a response. A late mem_data_ok arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from the state.
- IDLE: cmd_ready=1. On cmd_valid:
  - Latch the op, addr, tag and the steered wdata/wstrb.
  - If misaligned, go to RESP with rsp_ale=1.
  - Otherwise go to REQ.
- Misalignment rule: addr[size-1:0]!=0 for size>0. Size 3 with DATA_W=32 is also an alignment error.
- REQ: mem_req=1, with mem_addr, mem_wr, mem_size, mem_wstrb and mem_wdata held stable until mem_addr_ok. On mem_addr_ok, go to WAIT; mem_req drops in the next cycle.
- WAIT: mem_data_ok is sampled only in this state.
  - Memory must not assert data_ok in the same cycle as addr_ok.
  - On data_ok: for loads, register the extended rdata; for stores, rdata=0. Then go to RESP.
- RESP: rsp_valid=1 and its fields are held until rsp_ready, then go to IDLE. New commands are accepted only in IDLE (one outstanding transaction).
- Lane steering, with off = addr[log2(DATA_W/8)-1:0]:
  - wstrb = size mask (1, 3, F, FF) << off.
  - wdata = the low 2^size bytes of cmd_wdata, replicated across all lanes.
  - Load data = mem_rdata >> (8*off), truncated to the access size, then sign-extended (op[2]=0) or zero-extended (op[2]=1) to DATA_W.
- Latency, with the command accepted at edge T:
  - mem_req is high in cycle T+1.
  - With addr_ok at T+1 and data_ok at T+2, rsp_valid is high at T+3.
  - A misaligned command gives rsp_valid at T+1.
- stall_cnt increments every cycle the FSM is in REQ or WAIT. It saturates at all-ones and never wraps.
- rsp_ready held high while the FSM is not in RESP has no effect.

Test Plan:
- Load byte, DATA_W=32: ld.b at addr 0x1C000003, mem_rdata=0x80FF_1234, addr_ok and data_ok each after 0 waits -> rsp_rdata=0xFFFFFF80, rsp_valid at T+3, stall_cnt=2.
- Store half: st.h at addr 0x...2 with wdata 0xABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_wr=1, response rdata=0 with ale=0.
- Misaligned: ld.w at addr 0x...6 -> no mem_req ever; rsp_valid at T+1 with rsp_ale=1 and rsp_rd echoed.
- Backpressure: addr_ok delayed 3 cycles and data_ok delayed 2 more; rsp_ready held low 4 cycles -> request fields stable throughout, rsp fields stable, cmd_ready=0 until the response is taken, stall_cnt=7 (from 0).
- Reset in WAIT: resetn low for 1 cycle, then a stray data_ok in IDLE -> no rsp_valid, cmd_ready=1, stall_cnt=0.
- DATA_W=64: ld.hu at off 6 with mem_rdata=0x8001_0000_0000_0000 -> rsp_rdata=0x8001. ld.d at off 0 returns the full word. With CNT_W=2 and a long stall, stall_cnt sticks at 3.

Source files
------------

// File: rtl/mc_lsu.sv
// mc_lsu: load/store unit for the multi-cycle LoongArch core.
// The CPU offers one command and waits for one response. The LSU talks to
// data memory over an SRAM-like req/addr_ok/data_ok handshake, so memory
// latency can vary. It steers store lanes, builds write strobes, extends
// load data and flags misaligned accesses without touching memory.
module mc_lsu #(
  parameter int DATA_W = 32,  // 32 or 64
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  // CPU command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [4:0]            cmd_rd,
  // CPU response
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_ale,
  // memory side
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_data_ok,
  // performance
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic               ld_uns_q;
  logic [1:0]         ld_size_q;
  logic [OFF_W-1:0]   off_q;

  logic               misalign;
  logic [STRB_W-1:0]  size_mask;
  logic [STRB_W-1:0]  steer_wstrb;
  logic [DATA_W-1:0]  steer_wdata;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  load_ext;

  // Handshake flags are pure state decodes, so they change only on a clock edge.
  assign cmd_ready = (state == S_IDLE);
  assign mem_req   = (state == S_REQ);
  assign rsp_valid = (state == S_RESP);

  // Decode the incoming command: alignment check, byte-lane strobes and replicated store data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    misalign    = 1'b0;
    size_mask   = '0;
    steer_wdata = cmd_wdata;
    case (cmd_op[1:0])
      2'd0: begin
        misalign    = 1'b0;
        size_mask   = STRB_W'(1);
        steer_wdata = {STRB_W{cmd_wdata[7:0]}};
      end
      2'd1: begin
        misalign    = cmd_addr[0];
        size_mask   = STRB_W'(3);
        steer_wdata = {(STRB_W/2){cmd_wdata[15:0]}};
      end
      2'd2: begin
        misalign    = |cmd_addr[1:0];
        size_mask   = STRB_W'(15);
        steer_wdata = {(STRB_W/4){cmd_wdata[31:0]}};
      end
      default: begin
        // A doubleword cannot be carried on a 32-bit bus at all.
        misalign    = (DATA_W == 32) ? 1'b1 : (|cmd_addr[2:0]);
        size_mask   = '1;
        steer_wdata = cmd_wdata;
      end
    endcase
    steer_wstrb = size_mask << cmd_addr[OFF_W-1:0];
  end

  // Right-align the addressed lanes of the returned word and extend to full width.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (ld_size_q)
      2'd0: load_ext = ld_uns_q ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      2'd1: load_ext = ld_uns_q ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      2'd2: load_ext = ld_uns_q ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: load_ext = shifted;
    endcase
  end

  // Transaction FSM: accept in IDLE, hold the request until addr_ok, wait for
  // data_ok, hold the response until rsp_ready. Also runs the stall counter.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state     <= S_IDLE;
      ld_uns_q  <= 1'b0;
      ld_size_q <= 2'd0;
      off_q     <= '0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      rsp_ale   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            ld_uns_q  <= cmd_op[2];
            ld_size_q <= cmd_op[1:0];
            off_q     <= cmd_addr[OFF_W-1:0];
            mem_wr    <= cmd_op[3];
            mem_size  <= cmd_op[1:0];
            mem_addr  <= cmd_addr;
            // Loads never drive byte enables, so memory cannot mistake one for a write.
            mem_wstrb <= cmd_op[3] ? steer_wstrb : '0;
            mem_wdata <= steer_wdata;
            rsp_rd    <= cmd_rd;
            rsp_rdata <= '0;
            rsp_ale   <= misalign;
            state     <= misalign ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_addr_ok) state <= S_WAIT;
        end
        S_WAIT: begin
          // data_ok is only meaningful here; a stale one in any other state is dropped.
          if (mem_data_ok) begin
            rsp_rdata <= mem_wr ? '0 : load_ext;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (((state == S_REQ) || (state == S_WAIT)) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_lsu.sv
// Directed bench for mc_lsu: a 32-bit instance with a wide stall counter and
// a 64-bit instance with a 2-bit stall counter, driven from one initial block.
module tb_mc_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- 32-bit instance ----------------
  logic        resetn_a, cv_a, cr_a, rv_a, rr_a, ale_a, mreq_a, mwr_a, aok_a, dok_a;
  logic [3:0]  op_a, mstrb_a;
  logic [31:0] addr_a, wd_a, rdata_a, maddr_a, mwd_a, mrd_a, stall_a;
  logic [4:0]  rd_a, rrd_a;
  logic [1:0]  msize_a;

  mc_lsu #(.DATA_W(32), .ADDR_W(32), .CNT_W(32)) u_a (
    .clk(clk), .resetn(resetn_a),
    .cmd_valid(cv_a), .cmd_ready(cr_a), .cmd_op(op_a), .cmd_addr(addr_a),
    .cmd_wdata(wd_a), .cmd_rd(rd_a),
    .rsp_valid(rv_a), .rsp_ready(rr_a), .rsp_rdata(rdata_a), .rsp_rd(rrd_a), .rsp_ale(ale_a),
    .mem_req(mreq_a), .mem_wr(mwr_a), .mem_size(msize_a), .mem_addr(maddr_a),
    .mem_wstrb(mstrb_a), .mem_wdata(mwd_a), .mem_addr_ok(aok_a), .mem_rdata(mrd_a),
    .mem_data_ok(dok_a), .stall_cnt(stall_a)
  );

  // ---------------- 64-bit instance ----------------
  logic        resetn_b, cv_b, cr_b, rv_b, rr_b, ale_b, mreq_b, mwr_b, aok_b, dok_b;
  logic [3:0]  op_b;
  logic [7:0]  mstrb_b;
  logic [31:0] addr_b, maddr_b;
  logic [63:0] wd_b, rdata_b, mwd_b, mrd_b;
  logic [4:0]  rd_b, rrd_b;
  logic [1:0]  msize_b, stall_b;

  mc_lsu #(.DATA_W(64), .ADDR_W(32), .CNT_W(2)) u_b (
    .clk(clk), .resetn(resetn_b),
    .cmd_valid(cv_b), .cmd_ready(cr_b), .cmd_op(op_b), .cmd_addr(addr_b),
    .cmd_wdata(wd_b), .cmd_rd(rd_b),
    .rsp_valid(rv_b), .rsp_ready(rr_b), .rsp_rdata(rdata_b), .rsp_rd(rrd_b), .rsp_ale(ale_b),
    .mem_req(mreq_b), .mem_wr(mwr_b), .mem_size(msize_b), .mem_addr(maddr_b),
    .mem_wstrb(mstrb_b), .mem_wdata(mwd_b), .mem_addr_ok(aok_b), .mem_rdata(mrd_b),
    .mem_data_ok(dok_b), .stall_cnt(stall_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; observe and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn_a = 1'b0; cv_a = 1'b0; op_a = '0; addr_a = '0; wd_a = '0; rd_a = '0;
    rr_a = 1'b0; aok_a = 1'b0; dok_a = 1'b0; mrd_a = '0;
    resetn_b = 1'b0; cv_b = 1'b0; op_b = '0; addr_b = '0; wd_b = '0; rd_b = '0;
    rr_b = 1'b0; aok_b = 1'b0; dok_b = 1'b0; mrd_b = '0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_cmd_ready", 64'(cr_a), 64'd1);
    check("rst_rsp_valid", 64'(rv_a), 64'd0);
    check("rst_mem_req",   64'(mreq_a), 64'd0);
    check("rst_mem_wr",    64'(mwr_a), 64'd0);
    check("rst_rsp_ale",   64'(ale_a), 64'd0);
    check("rst_rsp_rdata", 64'(rdata_a), 64'd0);
    check("rst_mem_addr",  64'(maddr_a), 64'd0);
    check("rst_mem_wstrb", 64'(mstrb_a), 64'd0);
    check("rst_stall",     64'(stall_a), 64'd0);
    check("rst_b_stall",   64'(stall_b), 64'd0);
    resetn_a = 1'b1;
    resetn_b = 1'b1;
    tick();

    // ---- ld.b at 0x1C000003, zero-wait memory ----
    cv_a = 1'b1; op_a = 4'b0000; addr_a = 32'h1C00_0003; rd_a = 5'd5;
    tick();                                   // edge T: accept
    cv_a = 1'b0;
    check("ldb_mem_req_T1", 64'(mreq_a), 64'd1);
    check("ldb_cmd_ready",  64'(cr_a), 64'd0);
    check("ldb_mem_addr",   64'(maddr_a), 64'h1C00_0003);
    check("ldb_mem_wr",     64'(mwr_a), 64'd0);
    check("ldb_mem_size",   64'(msize_a), 64'd0);
    check("ldb_load_wstrb", 64'(mstrb_a), 64'd0);
    aok_a = 1'b1;
    tick();                                   // edge T+1: addr_ok
    aok_a = 1'b0;
    check("ldb_req_dropped", 64'(mreq_a), 64'd0);
    check("ldb_no_rsp_T2",   64'(rv_a), 64'd0);
    dok_a = 1'b1; mrd_a = 32'h80FF_1234;
    tick();                                   // edge T+2: data_ok
    dok_a = 1'b0;
    check("ldb_rsp_valid_T3", 64'(rv_a), 64'd1);
    check("ldb_rdata",        64'(rdata_a), 64'hFFFF_FF80);
    check("ldb_rd",           64'(rrd_a), 64'd5);
    check("ldb_ale",          64'(ale_a), 64'd0);
    check("ldb_stall",        64'(stall_a), 64'd2);
    rr_a = 1'b1;
    tick();
    rr_a = 1'b0;
    check("ldb_rsp_taken",  64'(rv_a), 64'd0);
    check("ldb_ready_back", 64'(cr_a), 64'd1);

    // ---- st.h at 0x1C000002, wdata 0xABCD ----
    cv_a = 1'b1; op_a = 4'b1001; addr_a = 32'h1C00_0002; wd_a = 32'h0000_ABCD; rd_a = 5'd7;
    tick();
    cv_a = 1'b0;
    check("sth_mem_req",   64'(mreq_a), 64'd1);
    check("sth_mem_wr",    64'(mwr_a), 64'd1);
    check("sth_mem_size",  64'(msize_a), 64'd1);
    check("sth_mem_wstrb", 64'(mstrb_a), 64'hC);
    check("sth_mem_wdata", 64'(mwd_a), 64'hABCD_ABCD);
    aok_a = 1'b1;
    tick();
    aok_a = 1'b0;
    dok_a = 1'b1; mrd_a = 32'hDEAD_BEEF;
    tick();
    dok_a = 1'b0;
    check("sth_rsp_valid", 64'(rv_a), 64'd1);
    check("sth_rdata",     64'(rdata_a), 64'd0);
    check("sth_ale",       64'(ale_a), 64'd0);
    check("sth_rd",        64'(rrd_a), 64'd7);
    rr_a = 1'b1;
    tick();
    rr_a = 1'b0;

    // ---- ld.w at 0x1C000006: misaligned ----
    cv_a = 1'b1; op_a = 4'b0010; addr_a = 32'h1C00_0006; rd_a = 5'd9;
    tick();
    cv_a = 1'b0;
    check("alw_rsp_valid_T1", 64'(rv_a), 64'd1);
    check("alw_ale",          64'(ale_a), 64'd1);
    check("alw_rd",           64'(rrd_a), 64'd9);
    check("alw_rdata",        64'(rdata_a), 64'd0);
    check("alw_no_req",       64'(mreq_a), 64'd0);
    tick();
    check("alw_still_no_req", 64'(mreq_a), 64'd0);
    check("alw_stall_frozen", 64'(stall_a), 64'd4);
    rr_a = 1'b1;
    tick();
    rr_a = 1'b0;

    // ---- ld.d on a 32-bit bus: always an alignment error ----
    cv_a = 1'b1; op_a = 4'b0011; addr_a = 32'h1C00_0008; rd_a = 5'd10;
    tick();
    cv_a = 1'b0;
    check("ald32_ale",    64'(ale_a), 64'd1);
    check("ald32_no_req", 64'(mreq_a), 64'd0);
    rr_a = 1'b1;
    tick();
    rr_a = 1'b0;

    // ---- backpressure: addr_ok after 3 waits, data_ok after 2 more, rsp_ready low 4 cycles ----
    resetn_a = 1'b0;
    tick();
    resetn_a = 1'b1;
    check("bp_stall_cleared", 64'(stall_a), 64'd0);
    cv_a = 1'b1; op_a = 4'b0001; addr_a = 32'h1C00_0012; rd_a = 5'd3;
    tick();
    cv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_req_held",  64'(mreq_a), 64'd1);
      check("bp_addr_held", 64'(maddr_a), 64'h1C00_0012);
      check("bp_size_held", 64'(msize_a), 64'd1);
      check("bp_cmd_ready", 64'(cr_a), 64'd0);
      aok_a = (i == 3);
      tick();
    end
    aok_a = 1'b0;
    mrd_a = 32'h8765_4321;
    for (int i = 0; i < 3; i++) begin
      check("bp_wait_no_req", 64'(mreq_a), 64'd0);
      check("bp_wait_no_rsp", 64'(rv_a), 64'd0);
      dok_a = (i == 2);
      tick();
    end
    dok_a = 1'b0;
    cv_a = 1'b1; op_a = 4'b0010; addr_a = 32'h1C00_0040; rd_a = 5'd30;   // must be ignored
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", 64'(rv_a), 64'd1);
      check("bp_rsp_rdata", 64'(rdata_a), 64'hFFFF_8765);
      check("bp_rsp_rd",    64'(rrd_a), 64'd3);
      check("bp_cmd_ready", 64'(cr_a), 64'd0);
      check("bp_stall",     64'(stall_a), 64'd7);
      tick();
    end
    cv_a = 1'b0;
    rr_a = 1'b1;
    tick();
    check("bp_rsp_taken",  64'(rv_a), 64'd0);
    check("bp_ready_back", 64'(cr_a), 64'd1);
    check("bp_stall_end",  64'(stall_a), 64'd7);

    // ---- reset in WAIT with rsp_ready held high, then a stray data_ok in IDLE ----
    cv_a = 1'b1; op_a = 4'b0010; addr_a = 32'h1C00_0020; rd_a = 5'd4;
    tick();
    cv_a = 1'b0;
    check("rw_req_ignores_ready", 64'(mreq_a), 64'd1);
    aok_a = 1'b1;
    tick();
    aok_a = 1'b0;
    check("rw_in_wait", 64'(rv_a | mreq_a | cr_a), 64'd0);
    resetn_a = 1'b0;
    tick();
    resetn_a = 1'b1;
    dok_a = 1'b1; mrd_a = 32'h1234_5678;
    tick();
    dok_a = 1'b0;
    check("rw_no_rsp",     64'(rv_a), 64'd0);
    check("rw_cmd_ready",  64'(cr_a), 64'd1);
    check("rw_stall",      64'(stall_a), 64'd0);
    check("rw_no_req",     64'(mreq_a), 64'd0);
    tick();
    check("rw_no_rsp_late", 64'(rv_a), 64'd0);
    rr_a = 1'b0;

    // ---- 64-bit: ld.hu at offset 6 ----
    cv_b = 1'b1; op_b = 4'b0101; addr_b = 32'h1C00_0006; rd_b = 5'd11;
    tick();
    cv_b = 1'b0;
    check("b_ldhu_req", 64'(mreq_b), 64'd1);
    aok_b = 1'b1;
    tick();
    aok_b = 1'b0;
    dok_b = 1'b1; mrd_b = 64'h8001_0000_0000_0000;
    tick();
    dok_b = 1'b0;
    check("b_ldhu_rdata", rdata_b, 64'h8001);
    check("b_ldhu_rd",    64'(rrd_b), 64'd11);
    check("b_ldhu_stall", 64'(stall_b), 64'd2);
    rr_b = 1'b1;
    tick();
    rr_b = 1'b0;

    // ---- 64-bit: ld.d at offset 0 returns the full word ----
    cv_b = 1'b1; op_b = 4'b0011; addr_b = 32'h1C00_0008; rd_b = 5'd12;
    tick();
    cv_b = 1'b0;
    check("b_ldd_req",  64'(mreq_b), 64'd1);
    check("b_ldd_size", 64'(msize_b), 64'd3);
    aok_b = 1'b1;
    tick();
    aok_b = 1'b0;
    dok_b = 1'b1; mrd_b = 64'h0123_4567_89AB_CDEF;
    tick();
    dok_b = 1'b0;
    check("b_ldd_rdata", rdata_b, 64'h0123_4567_89AB_CDEF);
    check("b_ldd_ale",   64'(ale_b), 64'd0);
    check("b_ldd_stall_sat", 64'(stall_b), 64'd3);
    rr_b = 1'b1;
    tick();
    rr_b = 1'b0;

    // ---- 64-bit: long stall from zero, counter sticks at 3 ----
    resetn_b = 1'b0;
    tick();
    resetn_b = 1'b1;
    check("b_sat_cleared", 64'(stall_b), 64'd0);
    cv_b = 1'b1; op_b = 4'b0010; addr_b = 32'h1C00_0010; rd_b = 5'd13;
    tick();
    cv_b = 1'b0;
    tick();
    tick();
    check("b_sat_two", 64'(stall_b), 64'd2);
    tick();
    check("b_sat_three", 64'(stall_b), 64'd3);
    tick();
    tick();
    tick();
    check("b_sat_stuck", 64'(stall_b), 64'd3);
    check("b_sat_req",   64'(mreq_b), 64'd1);
    aok_b = 1'b1;
    tick();
    aok_b = 1'b0;
    dok_b = 1'b1; mrd_b = 64'h0000_0000_8000_0000;
    tick();
    dok_b = 1'b0;
    check("b_ldw_sext",   rdata_b, 64'hFFFF_FFFF_8000_0000);
    check("b_sat_final",  64'(stall_b), 64'd3);
    rr_b = 1'b1;
    tick();
    rr_b = 1'b0;
    check("b_idle_back", 64'(cr_b), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
